stage_memory: RTL and testbench
===============================

# stage_memory

Memory stage of the five-stage RV32 pipeline, between execute and writeback. It consumes the registered execute results and performs loads and stores over a single-outstanding data-bus handshake. It resolves jumps and branches into a redirect pulse, and registers the writeback record. It also generates `mem_stall` back to execute while a bus access is in flight.

## Interface

Parameters: none.

- `clk` input 1: clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `mem_valid` input 1: execute holds a valid op; inputs below are stable while `mem_stall`=1.
- `mem_pc` input 32: op PC.
- `mem_data0` input 32: ALU result, which is one of: load/store address, link value PC+4, or branch compare bit in [0].
- `mem_data1` input 32: store data, or jump/branch target.
- `mem_read`, `mem_write` input 1 each: load / store.
- `mem_extend` input 1: 1 = sign-extend load data, 0 = zero-extend.
- `mem_width` input 2: 0 byte, 1 half, 2 word, 3 illegal.
- `mem_jmp`, `mem_br`, `mem_br_inv` input 1 each: jump; branch; invert compare bit.
- `wb_reg` input 5: destination register.
- `mem_stall` output 1: hold execute.
- `br_taken` output 1: redirect pulse; combinational.
- `br_target` output 32: `{mem_data1[31:1],1'b0}`; combinational.
- `mem_exc` output 1: registered one-cycle misaligned/illegal-access flag.
- `dbus_req` output 1: request, registered.
- `dbus_we` output 1: write.
- `dbus_addr` output 32: word address, bits [1:0]=0.
- `dbus_be` output 4: byte enables.
- `dbus_wdata` output 32: lane-replicated store data.
- `dbus_ack` input 1: request accepted/completed this cycle.
- `dbus_rdata` input 32: valid when `dbus_ack`=1 and the access is a read.
- `wb_valid` output 1: writeback record valid.
- `wb_pc_r` output 32: writeback record PC.
- `wb_reg_r` output 5: writeback record destination register.
- `wb_data` output 32: writeback record data.

## Operation

- `memop` = `mem_valid & (mem_read|mem_write)`.
- `bad` = `memop & (width==3 | (width==1 & addr[0]) | (width==2 & addr[1:0]!=0))`.
- A bad op issues no bus request. It retires in one cycle with `mem_exc`=1, `wb_valid`=1 and `wb_reg_r`=0.
- FSM states:
  - IDLE → BUSY when `memop & ~bad`. `dbus_req`/`we`/`addr`/`be`/`wdata` are registered on that edge.
  - BUSY → IDLE on the cycle `dbus_ack`=1. Load data is consumed combinationally that cycle.
- `dbus_req` is high exactly while in BUSY. Request fields stay constant until ack.
- Byte enables: byte → `0001<<addr[1:0]`; half → `0011<<addr[1:0]`; word → `1111`.
- Store data: byte → `{4{d[7:0]}}`; half → `{2{d[15:0]}}`; word → `d`.
- Load data: select lane by `addr[1:0]`, then zero- or sign-extend per `mem_extend` to 32 bits.
- `mem_stall` = `(state==IDLE & memop & ~bad) | (state==BUSY & ~dbus_ack)`.
- Branch taken = `mem_br & (mem_data0[0]^mem_br_inv)`; jump taken = `mem_jmp`.
- `br_taken` = `mem_valid & ~mem_stall & (jump taken | branch taken)`.
- Writeback register update, every edge:
  - If `mem_stall`: `wb_valid`<=0.
  - Otherwise: `wb_valid`<=`mem_valid` and `wb_pc_r`<=`mem_pc`.
  - `wb_reg_r`<=`wb_reg`, forced to 0 for stores, non-jump branches and bad ops.
  - `wb_data`<= extended load data for loads, else `mem_data0`.
- `mem_exc`<=`~mem_stall & bad`.

## Timing

- Reset values: state IDLE; `dbus_req`, `dbus_we`, `wb_valid`, `mem_exc` = 0; `dbus_addr`, `dbus_be`, `dbus_wdata`, `wb_pc_r`, `wb_reg_r`, `wb_data` = 0.
- Non-memory op: presented cycle N, `wb_*` valid cycle N+1, zero stall.
- Memory op with ack after k≥0 wait cycles (ack in the cycle `dbus_req` rises when k=0):
  - op at N; `dbus_req` high from N+1 through N+1+k.
  - `mem_stall` high from N through N+k.
  - `wb_valid` at N+2+k.
  - Minimum 2-cycle occupancy.
- Back-to-back memory ops: the next op is presented in the cycle after ack. `dbus_req` drops for at least one cycle between requests.
- `dbus_ack` while IDLE is ignored.
- `br_taken` fires only on the non-stalled cycle.
- Async reset in BUSY drops `dbus_req` immediately. The bus must tolerate an abandoned request.

## Test plan

- ADD result `mem_data0`=0x1234, `wb_reg`=5, no stall → next cycle `wb_valid`=1, `wb_reg_r`=5, `wb_data`=0x1234, `mem_stall` never high.
- LB signed, addr 0x103, `dbus_rdata`=0x80FF_FF_FF, ack 2 cycles after req → `dbus_addr`=0x100, `dbus_be`=1000, stall 3 cycles, `wb_data`=0xFFFFFF80. Repeat with `mem_extend`=0 → 0x00000080.
- SH addr 0x202, data 0xABCD1234, ack in the same cycle as req → `dbus_we`=1, `be`=1100, `wdata`=0x12341234, `wb_reg_r`=0.
- LW addr 0x301 → no `dbus_req`, `mem_exc`=1 for one cycle, `wb_reg_r`=0.
- BEQ with `mem_data0`=1, `br_inv`=0, `mem_data1`=0x401 → `br_taken`=1, `br_target`=0x400. Then `br_inv`=1 → `br_taken`=0. JAL with `mem_data0`=0x108, `wb_reg`=1 → `br_taken`=1, `wb_data`=0x108.
- Assert `reset_n`=0 while BUSY → `dbus_req`, `wb_valid` = 0 immediately; after release, a stale ack is ignored and the next LW completes normally.

Source files
------------

// File: rtl/stage_memory.sv
// stage_memory: memory stage of the five-stage RV32 pipeline.
//
// Takes the registered execute results, performs loads and stores over a
// single-outstanding data-bus handshake, turns jumps and taken branches into
// a combinational redirect pulse, and registers the writeback record.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   mem_valid .. wb_reg          op from execute, held stable while mem_stall=1
//   mem_stall                    hold execute while a bus access is pending
//   br_taken, br_target          redirect pulse and target (combinational)
//   mem_exc                      one-cycle misaligned/illegal access flag
//   dbus_req/we/addr/be/wdata    registered data-bus request
//   dbus_ack, dbus_rdata         bus completion and read data
//   wb_valid, wb_pc_r,
//   wb_reg_r, wb_data            registered writeback record
module stage_memory (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_data0,
    input  logic [31:0] mem_data1,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_extend,
    input  logic [1:0]  mem_width,
    input  logic        mem_jmp,
    input  logic        mem_br,
    input  logic        mem_br_inv,
    input  logic [4:0]  wb_reg,
    output logic        mem_stall,
    output logic        br_taken,
    output logic [31:0] br_target,
    output logic        mem_exc,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc_r,
    output logic [4:0]  wb_reg_r,
    output logic [31:0] wb_data
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        memop;
    logic        bad;
    logic        issue;
    logic        no_dest;
    logic [31:0] load_data;

    function automatic logic [3:0] byte_enables(input logic [1:0] width,
                                                input logic [1:0] ofs);
        case (width)
            2'd0:    byte_enables = 4'b0001 << ofs;
            2'd1:    byte_enables = 4'b0011 << ofs;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0]  width,
                                                input logic [31:0] d);
        case (width)
            2'd0:    store_lanes = {4{d[7:0]}};
            2'd1:    store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [1:0]  width,
                                                input logic        sext,
                                                input logic [1:0]  ofs,
                                                input logic [31:0] rdata);
        logic [31:0] lane;
        lane = rdata >> {ofs, 3'b000};
        case (width)
            2'd0:    load_extend = {{24{sext & lane[7]}}, lane[7:0]};
            2'd1:    load_extend = {{16{sext & lane[15]}}, lane[15:0]};
            default: load_extend = rdata;
        endcase
    endfunction

    assign memop = mem_valid & (mem_read | mem_write);
    assign bad   = memop & ((mem_width == 2'd3)
                          | ((mem_width == 2'd1) & mem_data0[0])
                          | ((mem_width == 2'd2) & (mem_data0[1:0] != 2'b00)));

    assign load_data = load_extend(mem_width, mem_extend, mem_data0[1:0], dbus_rdata);
    assign br_target = {mem_data1[31:1], 1'b0};

    // Stores, plain branches and faulting ops never write a register.
    assign no_dest = mem_write | (mem_br & ~mem_jmp) | bad;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (memop & ~bad) state_nxt = BUSY;
            BUSY:    if (dbus_ack)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        issue     = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                issue     = memop & ~bad;
                mem_stall = memop & ~bad;
            end
            BUSY:    mem_stall = ~dbus_ack;
            default: ;
        endcase
        br_taken = mem_valid & ~mem_stall
                 & (mem_jmp | (mem_br & (mem_data0[0] ^ mem_br_inv)));
    end

    // Bus request: fields latch on issue and hold until ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= 32'd0;
            dbus_be    <= 4'd0;
            dbus_wdata <= 32'd0;
        end else if (issue) begin
            dbus_req   <= 1'b1;
            dbus_we    <= mem_write;
            dbus_addr  <= {mem_data0[31:2], 2'b00};
            dbus_be    <= byte_enables(mem_width, mem_data0[1:0]);
            dbus_wdata <= store_lanes(mem_width, mem_data1);
        end else if ((state == BUSY) && dbus_ack) begin
            dbus_req   <= 1'b0;
        end
    end

    // Writeback record and exception flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid <= 1'b0;
            wb_pc_r  <= 32'd0;
            wb_reg_r <= 5'd0;
            wb_data  <= 32'd0;
            mem_exc  <= 1'b0;
        end else begin
            mem_exc <= ~mem_stall & bad;
            if (mem_stall) begin
                wb_valid <= 1'b0;
            end else begin
                wb_valid <= mem_valid;
                wb_pc_r  <= mem_pc;
                wb_reg_r <= no_dest ? 5'd0 : wb_reg;
                // A bad load never reached the bus, so it takes the ALU value.
                wb_data  <= (mem_read & ~mem_write & ~bad) ? load_data : mem_data0;
            end
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_data0;
    logic [31:0] mem_data1;
    logic        mem_read;
    logic        mem_write;
    logic        mem_extend;
    logic [1:0]  mem_width;
    logic        mem_jmp;
    logic        mem_br;
    logic        mem_br_inv;
    logic [4:0]  wb_reg;
    logic        mem_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        mem_exc;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        wb_valid;
    logic [31:0] wb_pc_r;
    logic [4:0]  wb_reg_r;
    logic [31:0] wb_data;

    int n_vec  = 0;
    int n_miss = 0;

    stage_memory dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_valid  (mem_valid),
        .mem_pc     (mem_pc),
        .mem_data0  (mem_data0),
        .mem_data1  (mem_data1),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_extend (mem_extend),
        .mem_width  (mem_width),
        .mem_jmp    (mem_jmp),
        .mem_br     (mem_br),
        .mem_br_inv (mem_br_inv),
        .wb_reg     (wb_reg),
        .mem_stall  (mem_stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .mem_exc    (mem_exc),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_be    (dbus_be),
        .dbus_wdata (dbus_wdata),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata),
        .wb_valid   (wb_valid),
        .wb_pc_r    (wb_pc_r),
        .wb_reg_r   (wb_reg_r),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_op();
        mem_valid  = 1'b0;
        mem_pc     = 32'd0;
        mem_data0  = 32'd0;
        mem_data1  = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_extend = 1'b0;
        mem_width  = 2'd0;
        mem_jmp    = 1'b0;
        mem_br     = 1'b0;
        mem_br_inv = 1'b0;
        wb_reg     = 5'd0;
    endtask

    // One memory op acknowledged k cycles after dbus_req rises.
    task automatic mem_access(input logic wr, input logic [31:0] pc,
                              input logic [31:0] addr, input logic [1:0] width,
                              input logic ext, input logic [31:0] d1,
                              input logic [31:0] rdata, input int k,
                              input logic [4:0] dst, input logic [31:0] eaddr,
                              input logic [3:0] ebe, input logic [31:0] ewdata,
                              input logic [31:0] ewb, input logic [4:0] ereg);
        int stalls;
        stalls = 0;
        @(posedge clk); #1;
        clear_op();
        mem_valid = 1'b1; mem_pc = pc; mem_data0 = addr; mem_data1 = d1;
        mem_read = ~wr; mem_write = wr; mem_width = width; mem_extend = ext;
        wb_reg = dst;
        @(negedge clk);
        chk("issue_req", {31'd0, dbus_req}, 32'd0);
        if (mem_stall) stalls++;
        for (int i = 0; i <= k; i++) begin
            @(posedge clk); #1;
            if (i == k) begin
                dbus_ack = 1'b1;
                dbus_rdata = rdata;
            end
            @(negedge clk);
            if (mem_stall) stalls++;
            chk("busy_req", {31'd0, dbus_req}, 32'd1);
            chk("busy_wbv", {31'd0, wb_valid}, 32'd0);
            chk("busy_stall", {31'd0, mem_stall}, (i == k) ? 32'd0 : 32'd1);
        end
        chk("bus_addr", dbus_addr, eaddr);
        chk("bus_be", {28'd0, dbus_be}, {28'd0, ebe});
        chk("bus_we", {31'd0, dbus_we}, {31'd0, wr});
        if (wr) chk("bus_wdata", dbus_wdata, ewdata);
        chk("stall_cycles", stalls, k + 1);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        dbus_rdata = 32'd0;
        clear_op();
        @(negedge clk);
        chk("wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_pc", wb_pc_r, pc);
        chk("wb_reg", {27'd0, wb_reg_r}, {27'd0, ereg});
        chk("wb_data", wb_data, ewb);
        chk("req_drop", {31'd0, dbus_req}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'd0;
        clear_op();
        @(negedge clk);
        chk("rst_req", {31'd0, dbus_req}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_exc", {31'd0, mem_exc}, 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_be", {28'd0, dbus_be}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_wbreg", {27'd0, wb_reg_r}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ALU op: one-cycle pass-through, no stall
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_pc = 32'h10; mem_data0 = 32'h1234; wb_reg = 5'd5;
        @(negedge clk);
        chk("add_stall", {31'd0, mem_stall}, 32'd0);
        chk("add_brt", {31'd0, br_taken}, 32'd0);
        @(posedge clk); #1;
        clear_op();
        @(negedge clk);
        chk("add_wbv", {31'd0, wb_valid}, 32'd1);
        chk("add_wbreg", {27'd0, wb_reg_r}, 32'd5);
        chk("add_wbdata", wb_data, 32'h1234);
        chk("add_stall2", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_wbv", {31'd0, wb_valid}, 32'd0);

        // LB signed / unsigned at 0x103, ack two cycles after req
        mem_access(1'b0, 32'h20, 32'h103, 2'd0, 1'b1, 32'd0, 32'h80FFFFFF, 2, 5'd7,
                   32'h100, 4'b1000, 32'd0, 32'hFFFFFF80, 5'd7);
        mem_access(1'b0, 32'h24, 32'h103, 2'd0, 1'b0, 32'd0, 32'h80FFFFFF, 2, 5'd7,
                   32'h100, 4'b1000, 32'd0, 32'h00000080, 5'd7);
        // LH signed from upper half
        mem_access(1'b0, 32'h28, 32'h106, 2'd1, 1'b1, 32'd0, 32'h9ABC5678, 1, 5'd8,
                   32'h104, 4'b1100, 32'd0, 32'hFFFF9ABC, 5'd8);
        // SH at 0x202, ack with req
        mem_access(1'b1, 32'h2C, 32'h202, 2'd1, 1'b0, 32'hABCD1234, 32'd0, 0, 5'd9,
                   32'h200, 4'b1100, 32'h12341234, 32'h202, 5'd0);
        // SB at 0x201
        mem_access(1'b1, 32'h30, 32'h201, 2'd0, 1'b0, 32'h000000A5, 32'd0, 1, 5'd9,
                   32'h200, 4'b0010, 32'hA5A5A5A5, 32'h201, 5'd0);

        // Misaligned LW: no request, one-cycle exception
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_pc = 32'h40; mem_read = 1'b1; mem_width = 2'd2;
        mem_data0 = 32'h301; wb_reg = 5'd3;
        @(negedge clk);
        chk("bad_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        clear_op();
        @(negedge clk);
        chk("bad_req", {31'd0, dbus_req}, 32'd0);
        chk("bad_exc", {31'd0, mem_exc}, 32'd1);
        chk("bad_wbv", {31'd0, wb_valid}, 32'd1);
        chk("bad_wbreg", {27'd0, wb_reg_r}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bad_exc_pulse", {31'd0, mem_exc}, 32'd0);

        // Branches and jump
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_pc = 32'h50; mem_br = 1'b1; mem_data0 = 32'd1;
        mem_data1 = 32'h401; wb_reg = 5'd4;
        @(negedge clk);
        chk("beq_taken", {31'd0, br_taken}, 32'd1);
        chk("beq_target", br_target, 32'h400);
        @(posedge clk); #1;
        mem_br_inv = 1'b1;
        @(negedge clk);
        chk("beq_inv", {31'd0, br_taken}, 32'd0);
        chk("br_wbreg", {27'd0, wb_reg_r}, 32'd0);
        @(posedge clk); #1;
        clear_op();
        mem_valid = 1'b1; mem_pc = 32'h104; mem_jmp = 1'b1; mem_data0 = 32'h108;
        mem_data1 = 32'h200; wb_reg = 5'd1;
        @(negedge clk);
        chk("jal_taken", {31'd0, br_taken}, 32'd1);
        chk("jal_target", br_target, 32'h200);
        @(posedge clk); #1;
        clear_op();
        @(negedge clk);
        chk("jal_wbdata", wb_data, 32'h108);
        chk("jal_wbreg", {27'd0, wb_reg_r}, 32'd1);

        // Async reset while BUSY, stale ack afterwards
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_read = 1'b1; mem_width = 2'd2; mem_data0 = 32'h300;
        wb_reg = 5'd11;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", {31'd0, dbus_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        clear_op();
        #1;
        chk("arst_req", {31'd0, dbus_req}, 32'd0);
        chk("arst_wbv", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        dbus_ack = 1'b1;
        dbus_rdata = 32'h55555555;
        @(negedge clk);
        chk("stale_req", {31'd0, dbus_req}, 32'd0);
        chk("stale_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("stale_wbv", {31'd0, wb_valid}, 32'd0);
        mem_access(1'b0, 32'h60, 32'h300, 2'd2, 1'b0, 32'd0, 32'hDEADBEEF, 1, 5'd11,
                   32'h300, 4'b1111, 32'd0, 32'hDEADBEEF, 5'd11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
